seg7_scan_reader: RTL

- Reader for the team's 7-segment HEX display path; recovers hex digits from segment patterns.
- Samples a multiplexed, active-low segment bus plus a one-hot digit-select bus, as driven by a display scanner or a HEX-port monitor.
- Debounces each pattern, decodes it to a 4-bit value and assembles a full frame of DIGITS nibbles.
- Used as a loopback checker and bench monitor for counter, accumulator and scrolling-message displays.

---
 rtl/seg7_scan_reader_if.sv | 44 ++++
 rtl/seg7_scan_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_reader_if.sv
// Bus between a 7-segment scanner (master) and the scan reader (slave).
// With SEG7_SCAN_DP_EN defined, the decimal point signals are added.
interface seg7_scan_reader_if #(
    parameter int unsigned DIGITS = 6
);
    logic [6:0]          seg_n;
    logic [DIGITS-1:0]   dig_sel;
    logic                cap_valid;
    logic [2:0]          cap_slot;
    logic [3:0]          cap_digit;
    logic                frame_valid;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   digit_bad;
    logic                sel_error;
`ifdef SEG7_SCAN_DP_EN
    logic                dp_n;
    logic                cap_dp;
    logic [DIGITS-1:0]   dp_mask;

    modport master (
        output seg_n, dig_sel, dp_n,
        input  cap_valid, cap_slot, cap_digit, cap_dp, frame_valid,
               digits, digit_bad, dp_mask, sel_error
    );

    modport slave (
        input  seg_n, dig_sel, dp_n,
        output cap_valid, cap_slot, cap_digit, cap_dp, frame_valid,
               digits, digit_bad, dp_mask, sel_error
    );
`else
    modport master (
        output seg_n, dig_sel,
        input  cap_valid, cap_slot, cap_digit, frame_valid,
               digits, digit_bad, sel_error
    );

    modport slave (
        input  seg_n, dig_sel,
        output cap_valid, cap_slot, cap_digit, frame_valid,
               digits, digit_bad, sel_error
    );
`endif
endinterface

// File: rtl/seg7_scan_reader.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus.
// Each sample is debounced, decoded and written to a per-position slot;
// a frame is published once every slot has been captured.
// Optional decimal point capture is enabled by defining SEG7_SCAN_DP_EN.
module seg7_scan_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned DIGITS        = 6
) (
    input logic               clk,
    input logic               reset,
    seg7_scan_reader_if.slave bus
);

    localparam int unsigned CNT_W = 8;
`ifdef SEG7_SCAN_DP_EN
    localparam int unsigned SAMPLE_W = DIGITS + 8;
`else
    localparam int unsigned SAMPLE_W = DIGITS + 7;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    state_t              state;
    logic [SAMPLE_W-1:0] sample_d;
    logic [SAMPLE_W-1:0] sample_q;
    logic [CNT_W-1:0]    stable_cnt;
    logic [DIGITS-1:0]   sel_q;
    logic [6:0]          seg_q;
    logic                sel_any;
    logic                sel_onehot;
    logic                stable_hit;
    logic [2:0]          sel_slot;
    logic [3:0]          dec_val;
    logic                dec_bad;
    logic                capture_fire;
    logic [DIGITS-1:0]   seen;
    logic                seen_full;
    logic [4*DIGITS-1:0] work_val;
    logic [4*DIGITS-1:0] work_val_next;
    logic [DIGITS-1:0]   work_bad;
    logic [DIGITS-1:0]   work_bad_next;
`ifdef SEG7_SCAN_DP_EN
    logic                dp_q;
    logic [DIGITS-1:0]   work_dp;
    logic [DIGITS-1:0]   work_dp_next;
`endif

    // Raw sample as compared for stability
    always_comb begin
`ifdef SEG7_SCAN_DP_EN
        sample_d = {bus.dp_n, bus.dig_sel, bus.seg_n};
`else
        sample_d = {bus.dig_sel, bus.seg_n};
`endif
    end

    // Input register and saturating run-length counter of identical samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q   <= '0;
            stable_cnt <= '0;
        end else begin
            sample_q <= sample_d;
            if (sample_d == sample_q) begin
                if (stable_cnt != CNT_MAX) begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    // Field split and select qualification of the registered sample
    always_comb begin
        sel_q      = sample_q[DIGITS+6:7];
        seg_q      = sample_q[6:0];
        sel_any    = |sel_q;
        sel_onehot = sel_any && ((sel_q & (sel_q - DIGITS'(1))) == '0);
        stable_hit = (stable_cnt == CNT_HIT);
        sel_slot   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sel_q[i]) begin
                sel_slot = 3'(i);
            end
        end
    end

`ifdef SEG7_SCAN_DP_EN
    assign dp_q = sample_q[SAMPLE_W-1];
`endif

    // Active-low segment pattern (g..a) to hex value
    always_comb begin
        dec_val = 4'h0;
        dec_bad = 1'b0;
        case (seg_q)
            7'b1000000: dec_val = 4'h0;
            7'b1111001: dec_val = 4'h1;
            7'b0100100: dec_val = 4'h2;
            7'b0110000: dec_val = 4'h3;
            7'b0011001: dec_val = 4'h4;
            7'b0010010: dec_val = 4'h5;
            7'b0000010: dec_val = 4'h6;
            7'b1111000: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0010000: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b0000011: dec_val = 4'hB;
            7'b1000110: dec_val = 4'hC;
            7'b0100001: dec_val = 4'hD;
            7'b0000110: dec_val = 4'hE;
            7'b0001110: dec_val = 4'hF;
            default: begin
                dec_val = 4'h0;
                dec_bad = 1'b1;
            end
        endcase
    end

    assign capture_fire = (state == SETTLE) && sel_any && stable_hit && sel_onehot;

    // Debounce FSM with registered capture and select-error outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bus.cap_valid <= 1'b0;
            bus.cap_slot  <= '0;
            bus.cap_digit <= '0;
            bus.sel_error <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            bus.cap_dp    <= 1'b0;
`endif
        end else begin
            bus.cap_valid <= 1'b0;
            bus.sel_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!sel_any) begin
                        state <= IDLE;
                    end else if (stable_hit) begin
                        state <= HELD;
                        if (sel_onehot) begin
                            bus.cap_valid <= 1'b1;
                            bus.cap_slot  <= sel_slot;
                            bus.cap_digit <= dec_val;
`ifdef SEG7_SCAN_DP_EN
                            bus.cap_dp    <= dp_q;
`endif
                        end else begin
                            bus.sel_error <= 1'b1;
                        end
                    end
                end
                HELD: begin
                    // Counter only returns to zero when the sample changes
                    if (stable_cnt == '0) begin
                        state <= sel_any ? SETTLE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Working slot contents after this cycle's capture, if any
    always_comb begin
        work_val_next = work_val;
        work_bad_next = work_bad;
`ifdef SEG7_SCAN_DP_EN
        work_dp_next  = work_dp;
`endif
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (capture_fire && sel_q[i]) begin
                work_val_next[4*i +: 4] = dec_val;
                work_bad_next[i]        = dec_bad;
`ifdef SEG7_SCAN_DP_EN
                work_dp_next[i]         = dp_q;
`endif
            end
        end
    end

    assign seen_full = (seen == {DIGITS{1'b1}});

    // Working slots, seen mask and frame publication
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen            <= '0;
            work_val        <= '0;
            work_bad        <= '0;
            bus.frame_valid <= 1'b0;
            bus.digits      <= '0;
            bus.digit_bad   <= '0;
`ifdef SEG7_SCAN_DP_EN
            work_dp         <= '0;
            bus.dp_mask     <= '0;
`endif
        end else begin
            work_val        <= work_val_next;
            work_bad        <= work_bad_next;
            bus.frame_valid <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            work_dp         <= work_dp_next;
`endif
            if (seen_full) begin
                // A capture landing on this edge is folded into the frame
                bus.frame_valid <= 1'b1;
                bus.digits      <= work_val_next;
                bus.digit_bad   <= work_bad_next;
`ifdef SEG7_SCAN_DP_EN
                bus.dp_mask     <= work_dp_next;
`endif
                seen            <= '0;
            end else if (capture_fire) begin
                seen <= seen | sel_q;
            end
        end
    end

endmodule
